serv_bufreg_w: RTL and testbench
================================

// Module: serv_bufreg_w
// PURPOSE
//  Parametrised successor of the bit-serial buffer register, processing W bits per beat.
//  It computes rs1+imm serially to form load/store/jump addresses, captures the two
//  address LSBs, and acts as a right-shift register for shift ops and the MDU operand.
//  It sits between the serial datapath (rs1/imm streams) and the dbus address/ext ports.
//  Adds W>1, an independent LSB capture register and a misalignment flag.
// PARAMETERS
//  W    1  bits per beat; legal values 1, 2, 4; one word = 32/W beats.
//  MDU  0  1 = MDU present; forces o_lsb to 0 while i_mdu_op is high.
// PORTS
//  i_clk        in   1   clock; all state updates on the rising edge.
//  i_rst        in   1   asynchronous, active-high reset.
//  i_cnt0       in   1   first beat of the word.
//  i_cnt1       in   1   second beat; used only when W=1.
//  i_en         in   1   beat enable; shift/carry advance only when high.
//  i_init       in   1   1 = load phase (accumulate sum), 0 = shift-out phase.
//  i_mdu_op     in   1   current instruction is an MDU op.
//  i_rs1_en     in   1   gate rs1 into the adder.
//  i_imm_en     in   1   gate imm into the adder.
//  i_clr_lsb    in   1   clear imm bit 0 on the first beat (JALR).
//  i_sh_signed  in   1   arithmetic right shift fill.
//  i_size       in   2   access size: 00 byte, 01 half, 10 word, 11 reserved.
//  i_rs1        in   W   rs1 slice, LSB-first.
//  i_imm        in   W   immediate slice, LSB-first.
//  o_q          out  W   serial output slice.
//  o_lsb        out  2   captured address bits [1:0].
//  o_misalign   out  1   access misaligned for i_size.
//  o_dbus_adr   out  32  word-aligned data bus address.
//  o_ext_rs1    out  32  full register contents to extensions.
// BEHAVIOUR
//  State:
//  - r[31:0]: shift register.
//  - c_r: carry flop.
//  - lsb_q[1:0]: LSB capture.
//  - All reset to 0 asynchronously on i_rst; all outputs therefore reset to 0.
//  Adder, per beat: {c,sum[W-1:0]} = (i_rs1 & {W{i_rs1_en}}) + (i_imm' & {W{i_imm_en}}) + c_r.
//  - i_imm' = i_imm with bit 0 forced 0 when i_cnt0 & i_clr_lsb.
//  - Modulo 2^32 overall; final carry discarded.
//  c_r <= c & i_en.
//  - Any i_en-low cycle clears carry before the next word.
//  - i_init=0 beats with i_en high propagate the adder carry unchanged.
//  Shift, when i_en:
//  - i_init=1: r <= {sum, r[31:W]}.
//  - i_init=0: r <= {{W{r[31] & i_sh_signed}}, r[31:W]}.
//  - No change when i_en=0.
//  - After 32/W init beats, r holds the full sum.
//  LSB capture:
//  - W=1: on i_init & i_cnt0, lsb_q[0]<=sum; on i_init & i_cnt1, lsb_q[1]<=sum.
//  - W>=2: on i_init & i_cnt0 & i_en, lsb_q <= sum[1:0].
//  - In all cases lsb_q holds otherwise.
//  - Valid 1 cycle after the capture beat (after cnt1 for W=1).
//  - Stable through the shift-out phase until the next init capture.
//  Outputs (combinational from state):
//  - o_q = r[W-1:0] & {W{i_en}}.
//  - o_dbus_adr = {r[31:2], 2'b00}.
//  - o_ext_rs1 = r.
//  - o_lsb = (MDU & i_mdu_op) ? 2'b00 : lsb_q.
//  - o_misalign = (i_size==01 & o_lsb[0]) | (i_size==10 & |o_lsb); 0 for size 00/11.
//  Boundaries:
//  - i_cnt0 & i_cnt1 both high: cnt0 action wins.
//  - i_rst mid-word clears all state; the next word computes correctly with no residue.
// TESTING
//  - W=1, rs1=0x1000_0003, imm=0x0000_0FFD, 32 init beats -> o_ext_rs1=0x1000_1000, o_lsb=00.
//  - W=4, same operands, 8 beats -> 0x1000_1000; o_lsb=00 one cycle after the cnt0 beat.
//  - W=4, rs1=0x100, imm=0x5, i_clr_lsb=1 -> r=0x104, o_lsb=00; with i_size=10 -> o_misalign=0.
//  - W=4, r=0x8000_0000, one non-init beat, i_sh_signed=1 -> 0xF800_0000; with i_sh_signed=0 -> 0x0800_0000.
//  - rs1=0xFFFF_FFFF, imm=1, then i_en low 1 cycle, then 0+0 -> second result 0 (carry cleared).
//  - W=2, i_rst pulsed at beat 5 -> r=0, c_r=0, o_lsb=0; restarted word 7+9 -> 0x10.
//  - MDU=1, lsb_q=11, i_mdu_op=1 -> o_lsb=00, o_misalign=0.

Source files
------------

// File: rtl/serv_bufreg_w_if.sv
// Bus bundle between the serial datapath and the W-bit buffer register.
// No latency of its own; it only carries wires.
// No backpressure: beats advance whenever the master raises i_en.
interface serv_bufreg_w_if #(
    parameter int W = 1
);
    logic         i_cnt0;
    logic         i_cnt1;
    logic         i_en;
    logic         i_init;
    logic         i_mdu_op;
    logic         i_rs1_en;
    logic         i_imm_en;
    logic         i_clr_lsb;
    logic         i_sh_signed;
    logic [1:0]   i_size;
    logic [W-1:0] i_rs1;
    logic [W-1:0] i_imm;
    logic [W-1:0] o_q;
    logic [1:0]   o_lsb;
    logic         o_misalign;
    logic [31:0]  o_dbus_adr;
    logic [31:0]  o_ext_rs1;

    modport master (
        output i_cnt0, i_cnt1, i_en, i_init, i_mdu_op, i_rs1_en, i_imm_en,
               i_clr_lsb, i_sh_signed, i_size, i_rs1, i_imm,
        input  o_q, o_lsb, o_misalign, o_dbus_adr, o_ext_rs1
    );

    modport slave (
        input  i_cnt0, i_cnt1, i_en, i_init, i_mdu_op, i_rs1_en, i_imm_en,
               i_clr_lsb, i_sh_signed, i_size, i_rs1, i_imm,
        output o_q, o_lsb, o_misalign, o_dbus_adr, o_ext_rs1
    );
endinterface

// File: rtl/serv_bufreg_w.sv
// W-bit-per-beat buffer register: serial rs1+imm adder, right shifter, address LSB capture.
// Sum is complete one cycle after the last of 32/W init beats; LSBs one cycle after the capture beat.
// No backpressure: state advances only on beats with i_en high, and holds otherwise.
module serv_bufreg_w #(
    parameter int W   = 1,
    parameter bit MDU = 1'b0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    serv_bufreg_w_if.slave  bus
);
    logic [31:0]  r_data;
    logic         r_c;
    logic [1:0]   r_lsb;

    logic [W-1:0] w_imm;
    logic [W:0]   w_add;
    logic [W-1:0] w_sum;
    logic         w_c;
    logic [1:0]   w_lsb;

    // JALR clears bit 0 of the target, which only ever lives in the first beat's slice
    always_comb begin
        w_imm = bus.i_imm;
        if (bus.i_cnt0 && bus.i_clr_lsb) begin
            w_imm[0] = 1'b0;
        end
    end

    assign w_add = {1'b0, bus.i_rs1 & {W{bus.i_rs1_en}}}
                 + {1'b0, w_imm & {W{bus.i_imm_en}}}
                 + {{W{1'b0}}, r_c};
    assign {w_c, w_sum} = w_add;

    // Carry chain plus shift register: accumulate the sum in load phase, shift out otherwise
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_c    <= 1'b0;
            r_data <= 32'h0000_0000;
        end else begin
            // An idle cycle between words drops any stale carry
            r_c <= w_c & bus.i_en;
            if (bus.i_en) begin
                if (bus.i_init) begin
                    r_data <= {w_sum, r_data[31:W]};
                end else begin
                    r_data <= {{W{r_data[31] & bus.i_sh_signed}}, r_data[31:W]};
                end
            end
        end
    end

    generate
        if (W == 1) begin : g_lsb_serial
            // One address bit per beat: bit 0 on the first beat, bit 1 on the second
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_lsb <= 2'b00;
                end else if (bus.i_init && bus.i_cnt0) begin
                    r_lsb[0] <= w_sum[0];
                end else if (bus.i_init && bus.i_cnt1) begin
                    r_lsb[1] <= w_sum[0];
                end
            end
        end else begin : g_lsb_parallel
            // Both address bits arrive together in the first beat's slice
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_lsb <= 2'b00;
                end else if (bus.i_init && bus.i_cnt0 && bus.i_en) begin
                    r_lsb <= w_sum[1:0];
                end
            end
        end
    endgenerate

    // Multiply/divide operands must not look like an unaligned address
    assign w_lsb = (MDU && bus.i_mdu_op) ? 2'b00 : r_lsb;

    assign bus.o_q        = r_data[W-1:0] & {W{bus.i_en}};
    assign bus.o_dbus_adr = {r_data[31:2], 2'b00};
    assign bus.o_ext_rs1  = r_data;
    assign bus.o_lsb      = w_lsb;
    assign bus.o_misalign = ((bus.i_size == 2'b01) && w_lsb[0])
                          | ((bus.i_size == 2'b10) && (|w_lsb));
endmodule

// File: tb/tb_serv_bufreg_w.sv
// Bench for serv_bufreg_w at W=1 (MDU=0), W=2 (MDU=1) and W=4 (MDU=0).
// A word-level model predicts every output on every cycle; literal checks pin the model.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
module tb_serv_bufreg_w;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Index 0: W=1 MDU=0, index 1: W=2 MDU=1, index 2: W=4 MDU=0
    logic [2:0]  en_s, init_s, cnt0_s, cnt1_s, mdu_s, rs1en_s, immen_s, clr_s, sgn_s;
    logic [1:0]  size_s [3];
    logic [3:0]  rs1_s  [3];
    logic [3:0]  imm_s  [3];
    logic [3:0]  q_o    [3];
    logic [1:0]  lsb_o  [3];
    logic [2:0]  mis_o;
    logic [31:0] adr_o  [3];
    logic [31:0] ext_o  [3];

    serv_bufreg_w_if #(.W(1)) bus1 ();
    serv_bufreg_w_if #(.W(2)) bus2 ();
    serv_bufreg_w_if #(.W(4)) bus4 ();

    serv_bufreg_w #(.W(1), .MDU(1'b0)) dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1));
    serv_bufreg_w #(.W(2), .MDU(1'b1)) dut2 (.i_clk(clk), .i_rst(rst), .bus(bus2));
    serv_bufreg_w #(.W(4), .MDU(1'b0)) dut4 (.i_clk(clk), .i_rst(rst), .bus(bus4));

    assign bus1.i_cnt0 = cnt0_s[0];  assign bus1.i_cnt1 = cnt1_s[0];   assign bus1.i_en = en_s[0];
    assign bus1.i_init = init_s[0];  assign bus1.i_mdu_op = mdu_s[0];  assign bus1.i_rs1_en = rs1en_s[0];
    assign bus1.i_imm_en = immen_s[0]; assign bus1.i_clr_lsb = clr_s[0]; assign bus1.i_sh_signed = sgn_s[0];
    assign bus1.i_size = size_s[0];  assign bus1.i_rs1 = rs1_s[0][0:0]; assign bus1.i_imm = imm_s[0][0:0];

    assign bus2.i_cnt0 = cnt0_s[1];  assign bus2.i_cnt1 = cnt1_s[1];   assign bus2.i_en = en_s[1];
    assign bus2.i_init = init_s[1];  assign bus2.i_mdu_op = mdu_s[1];  assign bus2.i_rs1_en = rs1en_s[1];
    assign bus2.i_imm_en = immen_s[1]; assign bus2.i_clr_lsb = clr_s[1]; assign bus2.i_sh_signed = sgn_s[1];
    assign bus2.i_size = size_s[1];  assign bus2.i_rs1 = rs1_s[1][1:0]; assign bus2.i_imm = imm_s[1][1:0];

    assign bus4.i_cnt0 = cnt0_s[2];  assign bus4.i_cnt1 = cnt1_s[2];   assign bus4.i_en = en_s[2];
    assign bus4.i_init = init_s[2];  assign bus4.i_mdu_op = mdu_s[2];  assign bus4.i_rs1_en = rs1en_s[2];
    assign bus4.i_imm_en = immen_s[2]; assign bus4.i_clr_lsb = clr_s[2]; assign bus4.i_sh_signed = sgn_s[2];
    assign bus4.i_size = size_s[2];  assign bus4.i_rs1 = rs1_s[2];      assign bus4.i_imm = imm_s[2];

    assign q_o[0] = {3'b000, bus1.o_q}; assign q_o[1] = {2'b00, bus2.o_q}; assign q_o[2] = bus4.o_q;
    assign lsb_o[0] = bus1.o_lsb; assign lsb_o[1] = bus2.o_lsb; assign lsb_o[2] = bus4.o_lsb;
    assign mis_o[0] = bus1.o_misalign; assign mis_o[1] = bus2.o_misalign; assign mis_o[2] = bus4.o_misalign;
    assign adr_o[0] = bus1.o_dbus_adr; assign adr_o[1] = bus2.o_dbus_adr; assign adr_o[2] = bus4.o_dbus_adr;
    assign ext_o[0] = bus1.o_ext_rs1;  assign ext_o[1] = bus2.o_ext_rs1;  assign ext_o[2] = bus4.o_ext_rs1;

    // Word-level model: the register is {sum, old value} viewed as 64 bits, shifted right by
    // the number of bits loaded so far; the full-word sum comes from plain 33-bit addition.
    logic [31:0] m_r [3], m_base [3], m_S [3], wA [3], wB [3];
    logic        m_c [3], m_cout [3], wclr [3];
    logic [1:0]  m_lsb [3];
    int          m_k [3];

    function automatic int wd(input int d);
        return (d == 0) ? 1 : (d == 1) ? 2 : 4;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_r[d] = '0; m_base[d] = '0; m_S[d] = '0; m_c[d] = 1'b0;
            m_cout[d] = 1'b0; m_lsb[d] = 2'b00; m_k[d] = 0;
        end
    endtask

    task automatic model_step(input int d);
        int          w;
        logic [32:0] full;
        logic [31:0] b;
        logic [63:0] cat;
        w = wd(d);
        if (!en_s[d]) begin
            m_c[d] = 1'b0;
            return;
        end
        if (init_s[d]) begin
            if (cnt0_s[d]) begin
                b = wB[d];
                if (wclr[d]) b[0] = 1'b0;
                full = {1'b0, wA[d]} + {1'b0, b} + {32'd0, m_c[d]};
                m_S[d] = full[31:0]; m_cout[d] = full[32];
                m_base[d] = m_r[d]; m_k[d] = 0;
                if (w == 1) m_lsb[d][0] = full[0];
                else        m_lsb[d] = full[1:0];
            end else if (cnt1_s[d] && w == 1) begin
                m_lsb[d][1] = m_S[d][1];
            end
            m_k[d]++;
            cat = {m_S[d], m_base[d]};
            m_r[d] = 32'(cat >> (m_k[d] * w));
            if (m_k[d] * w == 32) m_c[d] = m_cout[d];
        end else begin
            if (sgn_s[d]) m_r[d] = 32'($signed(m_r[d]) >>> w);
            else          m_r[d] = m_r[d] >> w;
        end
    endtask

    // Compare every output of every instance against the model on each falling edge
    logic [3:0] e_q;
    logic [1:0] e_l;
    logic       e_m;
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            e_q = 4'(m_r[d] & ((32'd1 << wd(d)) - 32'd1)) & {4{en_s[d]}};
            e_l = (d == 1 && mdu_s[d]) ? 2'b00 : m_lsb[d];
            e_m = (size_s[d] == 2'b01) ? e_l[0] : (size_s[d] == 2'b10) ? (|e_l) : 1'b0;
            check($sformatf("o_q W%0d", wd(d)), {28'd0, q_o[d]}, {28'd0, e_q});
            check($sformatf("o_ext_rs1 W%0d", wd(d)), ext_o[d], m_r[d]);
            check($sformatf("o_dbus_adr W%0d", wd(d)), adr_o[d], {m_r[d][31:2], 2'b00});
            check($sformatf("o_lsb W%0d", wd(d)), {30'd0, lsb_o[d]}, {30'd0, e_l});
            check($sformatf("o_misalign W%0d", wd(d)), {31'd0, mis_o[d]}, {31'd0, e_m});
        end
    end

    task automatic idle(input int d);
        en_s[d] = 1'b0; init_s[d] = 1'b0; cnt0_s[d] = 1'b0; cnt1_s[d] = 1'b0; mdu_s[d] = 1'b0;
        rs1en_s[d] = 1'b0; immen_s[d] = 1'b0; clr_s[d] = 1'b0; sgn_s[d] = 1'b0;
        size_s[d] = 2'b00; rs1_s[d] = 4'h0; imm_s[d] = 4'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        for (int d = 0; d < 3; d++) model_step(d);
        #1;
    endtask

    // Init beats kfrom..kto-1 of rs1=A + imm=B; a completed word is followed by an idle
    // cycle whose rs1 slice is all ones, so a carry that survives the idle cycle shows up.
    task automatic word(input int d, input logic [31:0] A, input logic [31:0] B,
                        input logic clr, input logic both, input int kfrom, input int kto);
        int w;
        w = wd(d);
        wA[d] = A; wB[d] = B; wclr[d] = clr;
        for (int k = kfrom; k < kto; k++) begin
            en_s[d] = 1'b1; init_s[d] = 1'b1; rs1en_s[d] = 1'b1; immen_s[d] = 1'b1; clr_s[d] = clr;
            cnt0_s[d] = (k == 0);
            cnt1_s[d] = (k == 1) || (k == 0 && both);
            rs1_s[d] = 4'((A >> (k * w)) & ((32'd1 << w) - 32'd1));
            imm_s[d] = 4'((B >> (k * w)) & ((32'd1 << w) - 32'd1));
            tick();
        end
        if (kto == 32 / w) begin
            idle(d);
            rs1en_s[d] = 1'b1;
            rs1_s[d] = 4'((32'd1 << w) - 32'd1);
            tick();
            idle(d);
        end
    endtask

    task automatic full(input int d, input logic [31:0] A, input logic [31:0] B, input logic clr);
        word(d, A, B, clr, 1'b0, 0, 32 / wd(d));
    endtask

    task automatic shift(input int d, input logic sgn, input int n);
        for (int k = 0; k < n; k++) begin
            en_s[d] = 1'b1; init_s[d] = 1'b0; sgn_s[d] = sgn;
            tick();
        end
        idle(d);
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) idle(d);
        model_reset();
        repeat (2) tick();
        #2;
        check("reset ext W1", ext_o[0], 32'h0);
        check("reset adr W4", adr_o[2], 32'h0);
        check("reset lsb W2", {30'd0, lsb_o[1]}, 32'h0);
        rst = 1'b0;
        tick();

        // W=1: cnt0 and cnt1 together on beat 0 -> only bit 0 captured; bit 1 on beat 1
        word(0, 32'h3, 32'h0, 1'b0, 1'b1, 0, 1);
        #2 check("W1 lsb after cnt0&cnt1", {30'd0, lsb_o[0]}, 32'h1);
        word(0, 32'h3, 32'h0, 1'b0, 1'b0, 1, 2);
        #2 check("W1 lsb after cnt1", {30'd0, lsb_o[0]}, 32'h3);
        word(0, 32'h3, 32'h0, 1'b0, 1'b0, 2, 32);
        check("W1 3+0", ext_o[0], 32'h3);
        mdu_s[0] = 1'b1; #1;
        check("W1 mdu_op without MDU keeps lsb", {30'd0, lsb_o[0]}, 32'h3);
        idle(0);

        full(0, 32'h1000_0003, 32'h0000_0FFD, 1'b0);
        check("W1 sum", ext_o[0], 32'h1000_1000);
        check("W1 lsb", {30'd0, lsb_o[0]}, 32'h0);

        // W=4: LSBs become 11 then are replaced one cycle after the next cnt0 beat
        full(2, 32'h3, 32'h0, 1'b0);
        size_s[2] = 2'b10; #1 check("W4 lsb=11 word misalign", {31'd0, mis_o[2]}, 32'h1);
        size_s[2] = 2'b01; #1 check("W4 lsb=11 half misalign", {31'd0, mis_o[2]}, 32'h1);
        idle(2);
        word(2, 32'h1000_0003, 32'h0000_0FFD, 1'b0, 1'b0, 0, 1);
        #2 check("W4 lsb after cnt0", {30'd0, lsb_o[2]}, 32'h0);
        word(2, 32'h1000_0003, 32'h0000_0FFD, 1'b0, 1'b0, 1, 8);
        check("W4 sum", ext_o[2], 32'h1000_1000);

        full(2, 32'h100, 32'h5, 1'b1);
        check("W4 clr_lsb sum", ext_o[2], 32'h104);
        size_s[2] = 2'b10; #1 check("W4 aligned word", {31'd0, mis_o[2]}, 32'h0);
        idle(2);
        full(2, 32'h100, 32'h6, 1'b0);
        check("W4 0x106 lsb", {30'd0, lsb_o[2]}, 32'h2);
        size_s[2] = 2'b01; #1 check("W4 lsb=10 half", {31'd0, mis_o[2]}, 32'h0);
        size_s[2] = 2'b10; #1 check("W4 lsb=10 word", {31'd0, mis_o[2]}, 32'h1);
        size_s[2] = 2'b11; #1 check("W4 lsb=10 reserved", {31'd0, mis_o[2]}, 32'h0);
        idle(2);

        full(2, 32'h8000_0000, 32'h0, 1'b0);
        shift(2, 1'b1, 1);
        check("W4 signed shift", ext_o[2], 32'hF800_0000);
        tick();
        full(2, 32'h8000_0000, 32'h0, 1'b0);
        shift(2, 1'b0, 1);
        check("W4 unsigned shift", ext_o[2], 32'h0800_0000);
        tick();

        full(2, 32'hFFFF_FFFF, 32'h1, 1'b0);
        check("W4 wrap sum", ext_o[2], 32'h0);
        full(2, 32'h0, 32'h0, 1'b0);
        check("W4 carry cleared", ext_o[2], 32'h0);

        // W=2: reset in the middle of a carry-heavy word, then a clean word
        word(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 5);
        #2;
        rst = 1'b1;
        model_reset();
        idle(1);
        #1;
        check("W2 mid-word reset ext", ext_o[1], 32'h0);
        check("W2 mid-word reset lsb", {30'd0, lsb_o[1]}, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        full(1, 32'h7, 32'h9, 1'b0);
        check("W2 7+9 after reset", ext_o[1], 32'h10);

        // MDU instance: an MDU op masks the captured LSBs and the misalignment flag
        full(1, 32'h3, 32'h0, 1'b0);
        size_s[1] = 2'b10; #1 check("W2 lsb=11 misalign", {31'd0, mis_o[1]}, 32'h1);
        mdu_s[1] = 1'b1; #1;
        check("W2 mdu_op lsb", {30'd0, lsb_o[1]}, 32'h0);
        check("W2 mdu_op misalign", {31'd0, mis_o[1]}, 32'h0);
        tick();
        idle(1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
